imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 8: linear instruction-memory address width; SHALL be even.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word width.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Fetch_req  input  1  fetch requester wants a read; held until granted.
REQ-006 Fetch_addr  input  ADDR_BITS  fetch read address, sampled in the grant cycle.
REQ-007 Fetch_gnt  output  1  combinational one-cycle grant to fetch.
REQ-008 Fetch_valid  output  1  registered one-cycle pulse; Fetch_data valid.
REQ-009 Fetch_data  output  DATA_WIDTH  read word; holds its last value between pulses.
REQ-010 Load_req / Load_addr / Load_data  input  1 / ADDR_BITS / DATA_WIDTH  program-loader write request, address and word.
REQ-011 Load_gnt  output  1  combinational one-cycle grant to loader.
REQ-012 Load_done  output  1  registered one-cycle pulse; write committed.
REQ-013 Mem_WriteEnable / Mem_X_addr / Mem_Y_addr / Mem_Data_in  output  1 / ADDR_BITS/2 / ADDR_BITS/2 / DATA_WIDTH  registered drive to the instruction memory.
REQ-014 Mem_Data_out  input  DATA_WIDTH  memory read word, updated by the memory on the clock edge after the address is presented.

Function
REQ-015 Address split SHALL be Mem_X_addr = addr[ADDR_BITS-1:ADDR_BITS/2], Mem_Y_addr = addr[ADDR_BITS/2-1:0].
REQ-016 FSM states IDLE, RD, CAP, WR; grants SHALL be issued only in IDLE, at most one per cycle.
REQ-017 Arbitration SHALL be 2-way round-robin: a sole requester is granted; if both request, grant the port not granted last.
REQ-018 Fetch grant in cycle T: X/Y registered, state IDLE->RD; T+1 RD->CAP; T+2 Fetch_data <= Mem_Data_out, CAP->IDLE; Fetch_valid high in T+3 only (latency 3).
REQ-019 Load grant in cycle T: X/Y, Mem_Data_in registered, Mem_WriteEnable=1 in T+1 only, IDLE->WR->IDLE; Load_done high in T+2 only.
REQ-020 A new grant SHALL be possible in the cycle Fetch_valid or Load_done pulses (back-to-back throughput: read every 3 cycles, write every 2).
REQ-021 Mem_WriteEnable SHALL be 0 in every state except WR; Mem_X/Y/Data_in hold between transactions.
REQ-022 Requests dropped before grant SHALL be ignored without side effects; non-granted request waits.

Reset
REQ-023 On Reset_n low: state IDLE, Fetch_valid, Load_done, Mem_WriteEnable, Mem_X_addr, Mem_Y_addr, Mem_Data_in, Fetch_data all 0; last-grant = loader (fetch wins first tie).
REQ-024 Reset mid-transaction SHALL abandon it: no Fetch_valid/Load_done pulse, no write after reset assertion.

Configuration
REQ-025 Macro IMEM_ARB_WRITE_PROTECT_EN: when defined, adds input Wp_lock (1) and output Load_err (1, reset 0); a load granted while Wp_lock=1 SHALL keep Mem_WriteEnable=0 and pulse Load_err instead of Load_done, same timing.
REQ-026 Without the macro, neither port exists and all granted loads write.

Structure
REQ-027 Package imem_pkg SHALL hold the FSM state enum and default ADDR_BITS/DATA_WIDTH constants.
REQ-028 Sub-module imem_rr_arbiter SHALL implement the 2-way round-robin grant and last-grant flag.

Verification
REQ-029 Fetch only, addr 0x37, memory[3][7]=0xDEADBEEF -> Fetch_gnt at T, Mem_X=3/Mem_Y=7 at T+1, Fetch_valid with 0xDEADBEEF at T+3.
REQ-030 Load addr 0xA5, data 0x12345678, then fetch 0xA5 -> Mem_WriteEnable one cycle, Load_done at T+2, fetch returns 0x12345678.
REQ-031 Both requesting continuously -> grants alternate fetch, load, fetch, load starting with fetch after reset.
REQ-032 Reset_n pulsed low during RD -> no Fetch_valid, all outputs 0, next fetch completes normally.
REQ-033 With IMEM_ARB_WRITE_PROTECT_EN and Wp_lock=1, load 0x10 data 0xFFFF_FFFF -> Load_err pulse at T+2, no Load_done, memory[1][0] unchanged on readback.

Source files
------------

// File: rtl/imem_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : imem_pkg                                               |
// | Description : Shared types and default sizes for the instruction-    |
// |               memory arbiter (FSM state encoding, default widths).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

  // Default linear address width (must be even: split into X/Y halves)
  localparam int unsigned IMEM_ADDR_BITS  = 8;
  // Default instruction word width
  localparam int unsigned IMEM_DATA_WIDTH = 32;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // accepting grants
    ST_RD   = 2'd1,  // address presented to memory
    ST_CAP  = 2'd2,  // memory word available, capture it
    ST_WR   = 2'd3   // write-enable asserted for one cycle
  } state_e;

endpackage : imem_pkg

`default_nettype wire

// File: rtl/imem_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | Module      : imem_rr_arbiter                                        |
// | Description : Two-way round-robin grant between the fetch and the    |
// |               loader requester. A sole requester always wins; on a   |
// |               tie the port that was not granted last wins.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_rr_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,          // grants allowed this cycle
  input  logic req_fetch_i,
  input  logic req_load_i,
  output logic gnt_fetch_o,
  output logic gnt_load_o
);

  // 1: loader was granted last, 0: fetch was granted last
  logic last_load_q;
  logic last_load_d;

  // Grant decision: sole requester wins, tie goes to the port not served last
  always_comb begin
    gnt_fetch_o = 1'b0;
    gnt_load_o  = 1'b0;
    if (en_i) begin
      if (req_fetch_i && req_load_i) begin
        gnt_fetch_o = last_load_q;
        gnt_load_o  = ~last_load_q;
      end else begin
        gnt_fetch_o = req_fetch_i;
        gnt_load_o  = req_load_i;
      end
    end
  end

  // Remember which port received the most recent grant
  always_comb begin
    last_load_d = last_load_q;
    if (gnt_fetch_o) begin
      last_load_d = 1'b0;
    end else if (gnt_load_o) begin
      last_load_d = 1'b1;
    end
  end

  // Last-grant flag; reset to "loader" so fetch wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_load_q <= 1'b1;
    end else begin
      last_load_q <= last_load_d;
    end
  end

endmodule : imem_rr_arbiter

`default_nettype wire

// File: rtl/imem_arbiter.sv
// +----------------------------------------------------------------------+
// | Module      : imem_arbiter                                           |
// | Description : Shares one synchronous instruction memory between the  |
// |               instruction fetch (reads, latency 3) and the program   |
// |               loader (writes, latency 2). Linear addresses are split |
// |               into X (upper half) and Y (lower half) coordinates.    |
// |               Optional macro IMEM_ARB_WRITE_PROTECT_EN adds the      |
// |               wp_lock_i / load_err_o pair that suppresses writes.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = IMEM_ADDR_BITS,  // must be even
  parameter int unsigned DATA_WIDTH = IMEM_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // Fetch (read) port
  input  logic                    fetch_req_i,
  input  logic [ADDR_BITS-1:0]    fetch_addr_i,
  output logic                    fetch_gnt_o,
  output logic                    fetch_valid_o,
  output logic [DATA_WIDTH-1:0]   fetch_data_o,
  // Loader (write) port
  input  logic                    load_req_i,
  input  logic [ADDR_BITS-1:0]    load_addr_i,
  input  logic [DATA_WIDTH-1:0]   load_data_i,
  output logic                    load_gnt_o,
  output logic                    load_done_o,
`ifdef IMEM_ARB_WRITE_PROTECT_EN
  input  logic                    wp_lock_i,
  output logic                    load_err_o,
`endif
  // Instruction memory drive
  output logic                    mem_write_enable_o,
  output logic [ADDR_BITS/2-1:0]  mem_x_addr_o,
  output logic [ADDR_BITS/2-1:0]  mem_y_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_in_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_out_i
);

  localparam int unsigned HALF = ADDR_BITS / 2;

  state_e                  state_q;
  logic                    fetch_valid_q;
  logic [DATA_WIDTH-1:0]   fetch_data_q;
  logic                    load_done_q;
  logic                    load_err_q;
  logic                    wp_hit_q;     // current load was blocked
  logic                    mem_we_q;
  logic [HALF-1:0]         mem_x_q;
  logic [HALF-1:0]         mem_y_q;
  logic [DATA_WIDTH-1:0]   mem_din_q;

  logic                    idle;
  logic                    fetch_gnt;
  logic                    load_gnt;
  logic                    wp_lock;

  assign idle = (state_q == ST_IDLE);

`ifdef IMEM_ARB_WRITE_PROTECT_EN
  assign wp_lock    = wp_lock_i;
  assign load_err_o = load_err_q;
`else
  assign wp_lock    = 1'b0;
`endif

  imem_rr_arbiter u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (idle),
    .req_fetch_i (fetch_req_i),
    .req_load_i  (load_req_i),
    .gnt_fetch_o (fetch_gnt),
    .gnt_load_o  (load_gnt)
  );

  // Transaction sequencer with registered memory drive and response pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      wp_hit_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_x_q       <= '0;
      mem_y_q       <= '0;
      mem_din_q     <= '0;
    end else begin
      // Response strobes are single-cycle by default
      fetch_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fetch_gnt) begin
            mem_x_q <= fetch_addr_i[ADDR_BITS-1:HALF];
            mem_y_q <= fetch_addr_i[HALF-1:0];
            state_q <= ST_RD;
          end else if (load_gnt) begin
            mem_x_q   <= load_addr_i[ADDR_BITS-1:HALF];
            mem_y_q   <= load_addr_i[HALF-1:0];
            mem_din_q <= load_data_i;
            // A locked load still walks through WR but never strobes the memory
            mem_we_q  <= ~wp_lock;
            wp_hit_q  <= wp_lock;
            state_q   <= ST_WR;
          end
        end
        ST_RD: begin
          // Memory samples X/Y on this edge; its word is ready next cycle
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          fetch_data_q  <= mem_data_out_i;
          fetch_valid_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        ST_WR: begin
          mem_we_q    <= 1'b0;
          load_done_q <= ~wp_hit_q;
          load_err_q  <= wp_hit_q;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign fetch_gnt_o        = fetch_gnt;
  assign load_gnt_o         = load_gnt;
  assign fetch_valid_o      = fetch_valid_q;
  assign fetch_data_o       = fetch_data_q;
  assign load_done_o        = load_done_q;
  assign mem_write_enable_o = mem_we_q;
  assign mem_x_addr_o       = mem_x_q;
  assign mem_y_addr_o       = mem_y_q;
  assign mem_data_in_o      = mem_din_q;

`ifndef IMEM_ARB_WRITE_PROTECT_EN
  // Error strobe has no output without write protection
  logic unused_err;
  assign unused_err = load_err_q;
`endif

endmodule : imem_arbiter

`default_nettype wire
